// File: rtl/seq_match_counter_pkg.sv
// Shared types, default parameters and helpers for the match-window counter.
package seq_match_counter_pkg;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    localparam int DEF_WIN_LEN = 16;
    localparam int DEF_CNT_W   = 8;

    // Increment that sticks at max_val instead of wrapping.
    function automatic logic [31:0] sat_inc(input logic [31:0] val, input logic [31:0] max_val);
        return (val >= max_val) ? max_val : val + 32'd1;
    endfunction

endpackage

// File: rtl/win_timer.sv
// Window timer: counts enabled cycles modulo WIN_LEN and flags the last one.
module win_timer #(
    parameter int WIN_LEN = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic last
);

    localparam int W = $clog2(WIN_LEN);
    localparam logic [W-1:0] PRE_LAST = W'(WIN_LEN - 2);

    logic [W-1:0] wcnt;

    // last is precomputed one step ahead so it is a flop, not a decode of wcnt.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (rst) begin
            wcnt <= '0;
            last <= 1'b0;
        end else if (en) begin
            if (last) begin
                wcnt <= '0;
                last <= 1'b0;
            end else begin
                wcnt <= wcnt + 1'b1;
                last <= (wcnt == PRE_LAST);
            end
        end
    end

endmodule

// File: rtl/seq_match_counter.sv
// Counts detector matches per window and hands each saturating count downstream
// over a valid/ready handshake with a sticky overrun flag.
module seq_match_counter
    import seq_match_counter_pkg::*;
#(
    parameter int WIN_LEN = DEF_WIN_LEN,
    parameter int CNT_W   = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             z,
    output logic [CNT_W-1:0] count_out,
    output logic             count_sat,
    output logic             count_valid,
    input  logic             count_ready,
    output logic             overrun
);

    localparam logic [CNT_W-1:0] MAX_CNT = '1;

    logic             last;
    logic             close;
    logic             at_max;
    logic [CNT_W-1:0] acc;
    logic [CNT_W-1:0] acc_inc;
    logic             sat_w;
    state_t           state;

    win_timer #(.WIN_LEN(WIN_LEN)) u_win_timer (
        .clk  (clk),
        .rst  (rst),
        .en   (en),
        .last (last)
    );

    assign close       = en & last;
    assign at_max      = (acc == MAX_CNT);
    assign acc_inc     = CNT_W'(sat_inc(32'(acc), 32'(MAX_CNT)));
    assign count_valid = (state == FULL);

    always_ff @(posedge clk) begin
        if (rst) begin
            acc       <= '0;
            sat_w     <= 1'b0;
            count_out <= '0;
            count_sat <= 1'b0;
            overrun   <= 1'b0;
            state     <= EMPTY;
        end else begin
            // The closing cycle's z still counts toward the window being closed.
            if (close) begin
                count_out <= z ? acc_inc : acc;
                count_sat <= sat_w | (z & at_max);
                acc       <= '0;
                sat_w     <= 1'b0;
            end else if (en & z) begin
                acc   <= acc_inc;
                sat_w <= sat_w | at_max;
            end

            case (state)
                EMPTY: begin
                    if (close) state <= FULL;
                end
                FULL: begin
                    if (close) begin
                        if (!count_ready) overrun <= 1'b1;
                    end else if (count_ready) begin
                        state <= EMPTY;
                    end
                end
                default: state <= EMPTY;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_match_counter.sv
// Self-checking bench: directed scenarios plus random traffic against a window-queue model.
module tb_seq_match_counter;

    localparam int WIN_LEN = 8;
    localparam int CNT_W   = 3;
    localparam int MAX     = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             en = 1'b0;
    logic             z = 1'b0;
    logic             count_ready = 1'b0;
    logic [CNT_W-1:0] count_out;
    logic             count_sat;
    logic             count_valid;
    logic             overrun;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: z samples of the open window, plus the output slot.
    bit m_q[$];
    int m_out     = 0;
    bit m_sat     = 1'b0;
    bit m_valid   = 1'b0;
    bit m_overrun = 1'b0;

    seq_match_counter #(.WIN_LEN(WIN_LEN), .CNT_W(CNT_W)) dut (
        .clk         (clk),
        .rst         (rst),
        .en          (en),
        .z           (z),
        .count_out   (count_out),
        .count_sat   (count_sat),
        .count_valid (count_valid),
        .count_ready (count_ready),
        .overrun     (overrun)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step(input logic r_i, input logic e_i, input logic z_i, input logic rdy_i);
        int sum;
        bit closed;
        rst         = r_i;
        en          = e_i;
        z           = z_i;
        count_ready = rdy_i;
        @(posedge clk);
        if (r_i) begin
            m_q.delete();
            m_out     = 0;
            m_sat     = 1'b0;
            m_valid   = 1'b0;
            m_overrun = 1'b0;
        end else begin
            if (e_i) m_q.push_back(z_i);
            closed = (m_q.size() == WIN_LEN);
            if (m_valid && rdy_i && !closed) m_valid = 1'b0;
            if (closed) begin
                sum = 0;
                foreach (m_q[i]) sum += int'(m_q[i]);
                if (m_valid && !rdy_i) m_overrun = 1'b1;
                m_valid = 1'b1;
                m_out   = (sum > MAX) ? MAX : sum;
                m_sat   = (sum > MAX);
                m_q.delete();
            end
        end
        #1;
        check("count_valid", 32'(count_valid), 32'(m_valid));
        check("count_out",   32'(count_out),   32'(m_out));
        check("count_sat",   32'(count_sat),   32'(m_sat));
        check("overrun",     32'(overrun),     32'(m_overrun));
        @(negedge clk);
    endtask

    // One full enabled window; bit i of zbits is z on window cycle i.
    task automatic run_window(input logic [WIN_LEN-1:0] zbits, input logic rdy_i);
        for (int i = 0; i < WIN_LEN; i++) step(1'b0, 1'b1, zbits[i], rdy_i);
    endtask

    initial begin
        // Reset, then idle with en low
        step(1'b1, 1'b0, 1'b0, 1'b0);
        check("reset_valid", 32'(count_valid), 32'd0);
        check("reset_out", 32'(count_out), 32'd0);
        for (int i = 0; i < 20; i++) step(1'b0, 1'b0, 1'b1, 1'b0);
        check("idle_valid", 32'(count_valid), 32'd0);

        // z on cycles 2 and 7 with ready held high
        run_window(8'b1000_0100, 1'b1);
        check("win2_valid", 32'(count_valid), 32'd1);
        check("win2_out", 32'(count_out), 32'd2);
        check("win2_sat", 32'(count_sat), 32'd0);

        // Saturating window, then an empty one
        run_window(8'b1111_1111, 1'b1);
        check("sat_out", 32'(count_out), 32'd7);
        check("sat_flag", 32'(count_sat), 32'd1);
        run_window(8'b0000_0000, 1'b1);
        check("zero_out", 32'(count_out), 32'd0);
        check("zero_sat", 32'(count_sat), 32'd0);

        // Two closes without ready: overwrite and overrun
        run_window(8'b0000_0111, 1'b0);
        run_window(8'b0001_1111, 1'b0);
        check("ovr_out", 32'(count_out), 32'd5);
        check("ovr_flag", 32'(overrun), 32'd1);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        check("ovr_drain_valid", 32'(count_valid), 32'd0);
        check("ovr_sticky", 32'(overrun), 32'd1);

        // en low for 4 cycles mid-window with z high: ignored, close delayed by 4
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b1, 1'b1);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 1'b0, 1'b1);
        check("gap_not_closed", 32'(count_valid), 32'd0);
        step(1'b0, 1'b1, 1'b0, 1'b1);
        check("gap_closed", 32'(count_valid), 32'd1);
        check("gap_out", 32'(count_out), 32'd0);

        // Reset while FULL and mid-window with acc=3
        run_window(8'b0000_0011, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b1, 1'b0);
        check("rst_valid", 32'(count_valid), 32'd0);
        check("rst_overrun", 32'(overrun), 32'd0);
        check("rst_out", 32'(count_out), 32'd0);
        run_window(8'b0100_0000, 1'b1);
        check("post_rst_out", 32'(count_out), 32'd1);

        // Random traffic with occasional resets
        for (int i = 0; i < 600; i++) begin
            step(($urandom_range(0, 79) == 0),
                 ($urandom_range(0, 3) != 0),
                 1'($urandom_range(0, 1)),
                 ($urandom_range(0, 2) != 0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
